// File: rtl/single_ram_if.sv
// single_ram_if: SRAM-style control bus (address, chip select, write enable, output enable).
interface single_ram_if #(parameter int ADDR_WIDTH = 8);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  cs;
    logic                  we;
    logic                  oe;
    modport master (output addr, cs, we, oe);
    modport slave  (input  addr, cs, we, oe);
endinterface

// File: rtl/single_ram.sv
// single_ram: resettable register-array RAM with sync write and combinational read on a shared tristate bus.
module single_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    single_ram_if.slave           bus,
    inout  wire  [DATA_WIDTH-1:0] data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_rd;
    // a write cycle owns the bus even with oe high, so the read path never contends with the master
    assign w_rd = !rst && bus.cs && !bus.we && bus.oe;
    assign data = w_rd ? r_mem[bus.addr] : {DATA_WIDTH{1'bz}};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (bus.cs && bus.we) begin
            r_mem[bus.addr] <= data;
        end
    end
endmodule

// File: tb/tb_single_ram.sv
// tb_single_ram: directed stimulus feeding an expectation queue; a monitor pops and compares the bus.
module tb_single_ram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] drv = '0;
    logic        drv_en = 1'b0;
    wire  [31:0] data;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        string       name;
        logic        z;
        logic [31:0] val;
    } exp_t;
    exp_t q[$];
    event chk;

    always #5 clk = ~clk;

    single_ram_if #(.ADDR_WIDTH(8)) bus ();
    assign data = drv_en ? drv : 32'bz;

    single_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .data (data)
    );

    initial begin
        exp_t e;
        forever begin
            @(chk);
            e = q.pop_front();
            n_cmp++;
            if (e.z) begin
                if (data !== 32'bz) begin
                    n_bad++;
                    $display("FAIL %s: bus=%h required=high-Z", e.name, data);
                end
            end else if (data !== e.val) begin
                n_bad++;
                $display("FAIL %s: bus=%h required=%h", e.name, data, e.val);
            end
        end
    end

    task automatic expect_bus(input string n, input logic z, input logic [31:0] v);
        q.push_back('{n, z, v});
        #2;
        ->chk;
        #1;
    endtask

    task automatic set_ctl(input logic [7:0] a, input logic c, input logic w, input logic o);
        bus.addr = a;
        bus.cs   = c;
        bus.we   = w;
        bus.oe   = o;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] v, input logic c, input logic o);
        @(negedge clk);
        set_ctl(a, c, 1'b1, o);
        drv    = v;
        drv_en = 1'b1;
        @(posedge clk);
        #1;
        drv_en = 1'b0;
        set_ctl(a, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string n, input logic [7:0] a, input logic c, input logic o,
                      input logic z, input logic [31:0] v);
        @(negedge clk);
        drv_en = 1'b0;
        set_ctl(a, c, 1'b0, o);
        expect_bus(n, z, v);
    endtask

    initial begin
        set_ctl(8'h00, 1'b1, 1'b0, 1'b1);
        #3;
        expect_bus("rst_hiz", 1'b1, '0);
        @(negedge clk);
        rst = 1'b0;
        rd("rst_00", 8'h00, 1'b1, 1'b1, 1'b0, 32'h0);
        rd("rst_7f", 8'h7F, 1'b1, 1'b1, 1'b0, 32'h0);
        rd("rst_ff", 8'hFF, 1'b1, 1'b1, 1'b0, 32'h0);

        wr(8'hA5, 32'hDEADBEEF, 1'b1, 1'b0);
        wr(8'h5A, 32'h55AAFF00, 1'b1, 1'b0);
        rd("rd_a5", 8'hA5, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        rd("rd_5a", 8'h5A, 1'b1, 1'b1, 1'b0, 32'h55AAFF00);

        rd("cs0_hiz", 8'hA5, 1'b0, 1'b1, 1'b1, '0);
        wr(8'hA5, 32'h12345678, 1'b0, 1'b0);
        rd("cs0_nowr", 8'hA5, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);

        rd("oe0_hiz", 8'hA5, 1'b1, 1'b0, 1'b1, '0);
        @(negedge clk);
        set_ctl(8'h10, 1'b1, 1'b1, 1'b1);
        drv    = 32'hCAFEF00D;
        drv_en = 1'b1;
        expect_bus("weoe_nodrv", 1'b0, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        drv_en = 1'b0;
        set_ctl(8'h10, 1'b0, 1'b0, 1'b0);
        rd("rd_10", 8'h10, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D);

        wr(8'h00, 32'h00000001, 1'b1, 1'b0);
        wr(8'hFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        rd("rd_00_first", 8'h00, 1'b1, 1'b1, 1'b0, 32'h00000001);
        wr(8'h00, 32'hA5A5A5A5, 1'b1, 1'b0);
        rd("rd_00_ovr", 8'h00, 1'b1, 1'b1, 1'b0, 32'hA5A5A5A5);
        rd("rd_ff", 8'hFF, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF);
        // address swings without a clock edge must show up on the bus directly
        bus.addr = 8'h00;
        expect_bus("comb_00", 1'b0, 32'hA5A5A5A5);
        bus.addr = 8'hFF;
        expect_bus("comb_ff", 1'b0, 32'hFFFFFFFF);

        rd("pre_rst_a5", 8'hA5, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        rst = 1'b1;
        expect_bus("async_rst_hiz", 1'b1, '0);
        @(negedge clk);
        set_ctl(8'h20, 1'b1, 1'b1, 1'b0);
        drv    = 32'h0BADF00D;
        drv_en = 1'b1;
        @(posedge clk);
        #1;
        drv_en = 1'b0;
        set_ctl(8'hA5, 1'b1, 1'b0, 1'b1);
        expect_bus("rst_rd_hiz", 1'b1, '0);
        @(negedge clk);
        rst = 1'b0;
        rd("post_rst_a5", 8'hA5, 1'b1, 1'b1, 1'b0, 32'h0);
        rd("post_rst_20", 8'h20, 1'b1, 1'b1, 1'b0, 32'h0);
        rd("post_rst_ff", 8'hFF, 1'b1, 1'b1, 1'b0, 32'h0);

        #5;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: pending=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
